// File: rtl/monitor_pkg.sv
// monitor_pkg: classification codes, scheduler FSM encoding and shared types
// for the thermal monitor sample scheduler.
package monitor_pkg;

   localparam logic [3:0] ST_NORMAL     = 4'd0;
   localparam logic [3:0] ST_BORDERLINE = 4'd1;
   localparam logic [3:0] ST_ATTENTION  = 4'd2;
   localparam logic [3:0] ST_EMERGENCY  = 4'd3;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REQ    = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_EVAL   = 3'd4;

   // Clocks from the ack edge to the cur_state update.
   localparam int unsigned EVAL_LATENCY = 3;

   typedef struct packed {
      logic [5:0] temp;
      logic [3:0] frac;
   } sample_t;

   // Codes above EMERGENCY are undefined at the monitor and are treated as EMERGENCY.
   function automatic logic [3:0] clamp_class(input logic [3:0] raw);
      return (raw > ST_EMERGENCY) ? ST_EMERGENCY : raw;
   endfunction

endpackage

// File: rtl/period_timer.sv
// period_timer: reusable down-counter; clr reloads COUNT-1, en counts down,
// term pulses on the COUNT-th enabled cycle after a clear.
module period_timer #(
   parameter int unsigned COUNT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic term
);

   localparam int unsigned W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [W-1:0] RELOAD = W'(COUNT - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = RELOAD;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign term = en && !clr && (cnt_q == '0);

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/monitor_scheduler.sv
// monitor_scheduler: periodic sensor req/ack sampling, held monitor inputs, classification
// capture and latched alarm. Define MONITOR_SCHED_MANUAL_EN to add the manual_trig input.
module monitor_scheduler
   import monitor_pkg::*;
#(
   parameter int unsigned SAMPLE_PERIOD  = 50_000_000,
   parameter int unsigned SENSOR_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
`ifdef MONITOR_SCHED_MANUAL_EN
   input  logic       manual_trig,
`endif
   output logic       sensor_req,
   input  logic       sensor_ack,
   input  logic [5:0] sensor_temp,
   input  logic [3:0] sensor_frac,
   output logic [5:0] mon_temp,
   output logic [3:0] mon_frac,
   input  logic [3:0] mon_state,
   input  logic       alarm_ack,
   output logic       alarm,
   output logic [3:0] cur_state,
   output logic       sensor_fault,
   output logic [7:0] sample_cnt
);

   logic [2:0] state_q, state_d;
   sample_t    cap_q, cap_d;
   sample_t    mon_q, mon_d;
   logic [3:0] cur_state_q, cur_state_d;
   logic       sensor_fault_q, sensor_fault_d;
   logic       alarm_q, alarm_d;
   logic [7:0] sample_cnt_q, sample_cnt_d;
   logic       sensor_req_q, sensor_req_d;

   logic       alarm_set;
   logic       period_term;
   logic       timeout_term;
   logic       manual_go;
   logic [3:0] eval_class;
   logic       in_idle;
   logic       in_req;

`ifdef MONITOR_SCHED_MANUAL_EN
   assign manual_go = manual_trig;
`else
   assign manual_go = 1'b0;
`endif

   assign in_idle    = (state_q == S_IDLE);
   assign in_req     = (state_q == S_REQ);
   assign eval_class = clamp_class(mon_state);

   // Both timers reload whenever their state is not active, so each entry starts a fresh count.
   period_timer #(
      .COUNT (SAMPLE_PERIOD)
   ) u_period_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (!in_idle),
      .en   (in_idle),
      .term (period_term)
   );

   period_timer #(
      .COUNT (SENSOR_TIMEOUT)
   ) u_timeout_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (!in_req),
      .en   (in_req),
      .term (timeout_term)
   );

   always_comb begin
      state_d        = state_q;
      cap_d          = cap_q;
      mon_d          = mon_q;
      cur_state_d    = cur_state_q;
      sensor_fault_d = sensor_fault_q;
      sample_cnt_d   = sample_cnt_q;
      alarm_set      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (period_term || manual_go) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // An ack on the final timeout cycle still wins over the timeout.
            if (sensor_ack) begin
               cap_d   = '{temp: sensor_temp, frac: sensor_frac};
               state_d = S_LOAD;
            end else if (timeout_term) begin
               sensor_fault_d = 1'b1;
               cur_state_d    = ST_EMERGENCY;
               sample_cnt_d   = sample_cnt_q + 8'd1;
               alarm_set      = 1'b1;
               state_d        = S_IDLE;
            end
         end
         S_LOAD: begin
            mon_d          = cap_q;
            sensor_fault_d = 1'b0;
            state_d        = S_SETTLE;
         end
         S_SETTLE: begin
            state_d = S_EVAL;
         end
         S_EVAL: begin
            cur_state_d  = eval_class;
            sample_cnt_d = sample_cnt_q + 8'd1;
            alarm_set    = (eval_class == ST_EMERGENCY);
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      sensor_req_d = (state_d == S_REQ);

      // A set event beats a simultaneous clear; clears are refused while still in emergency.
      alarm_d = alarm_q;
      if (alarm_set) begin
         alarm_d = 1'b1;
      end else if (alarm_ack && (cur_state_q != ST_EMERGENCY) && !sensor_fault_q) begin
         alarm_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         mon_q          <= '0;
         cur_state_q    <= ST_NORMAL;
         sensor_fault_q <= 1'b0;
         alarm_q        <= 1'b0;
         sample_cnt_q   <= '0;
         sensor_req_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         mon_q          <= mon_d;
         cur_state_q    <= cur_state_d;
         sensor_fault_q <= sensor_fault_d;
         alarm_q        <= alarm_d;
         sample_cnt_q   <= sample_cnt_d;
         sensor_req_q   <= sensor_req_d;
      end
   end

   // NOTE: the capture register is only read in LOAD after an ack wrote it, so it needs no reset.
   always_ff @(posedge clk) begin
      cap_q <= cap_d;
   end

   assign sensor_req   = sensor_req_q;
   assign mon_temp     = mon_q.temp;
   assign mon_frac     = mon_q.frac;
   assign cur_state    = cur_state_q;
   assign sensor_fault = sensor_fault_q;
   assign alarm        = alarm_q;
   assign sample_cnt   = sample_cnt_q;

endmodule
